// File: rtl/ctrl_edicion.sv
// Programming-mode controller: edge-detects debounced buttons, runs the mode FSM,
// the field cursor, inc/dec strobes with hold-to-repeat, and the 12h / chrono flags.
module ctrl_edicion #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       au,
  input  logic       dis,
  input  logic       l,
  input  logic       r,
  input  logic       f,
  input  logic       prh,
  input  logic       prf,
  input  logic       prc,
  input  logic       icr,
  output logic [1:0] mode,
  output logic       edit_active,
  output logic [1:0] field,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       fmt_12h,
  output logic       crono_run
);

  typedef enum logic [1:0] {NORMAL = 2'b00, HORA = 2'b01, FECHA = 2'b10, CRONO = 2'b11} mode_t;
  typedef enum logic [1:0] {RP_IDLE = 2'b00, RP_DELAY = 2'b01, RP_RATE = 2'b10} rep_t;

  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  localparam int B_AU = 0, B_DIS = 1, B_L = 2, B_R = 3, B_F = 4,
                 B_PRH = 5, B_PRF = 6, B_PRC = 7, B_ICR = 8;

  logic [8:0]       r_prev;
  mode_t            r_mode, w_mode_nxt;
  rep_t             r_rep, w_rep_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;     // 0: au repeating, 1: dis repeating
  logic [1:0]       r_field, w_field_nxt;
  logic             r_inc, w_inc_nxt;
  logic             r_dec, w_dec_nxt;
  logic             r_fmt, w_fmt_nxt;
  logic             r_crono, w_crono_nxt;
  logic             r_edit;

  logic [8:0]       w_lvl, w_rise;
  logic             w_mode_chg;
  logic             w_held;
  logic [CNT_W-1:0] w_limit;

  assign w_lvl  = {icr, prc, prf, prh, f, r, l, dis, au};
  // Previous levels reset to 1 so a button held across reset yields no event.
  assign w_rise = w_lvl & ~r_prev;

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_rise[B_PRH])      w_mode_nxt = (r_mode == HORA)  ? NORMAL : HORA;
    else if (w_rise[B_PRF]) w_mode_nxt = (r_mode == FECHA) ? NORMAL : FECHA;
    else if (w_rise[B_PRC]) w_mode_nxt = (r_mode == CRONO) ? NORMAL : CRONO;
    w_mode_chg = (w_mode_nxt != r_mode);
  end

  always_comb begin
    w_field_nxt = r_field;
    if (w_mode_chg || r_mode == NORMAL) begin
      w_field_nxt = 2'd0;
    end else if (w_rise[B_R] && !w_rise[B_L]) begin
      w_field_nxt = (r_field == 2'd2) ? 2'd0 : r_field + 2'd1;
    end else if (w_rise[B_L] && !w_rise[B_R]) begin
      w_field_nxt = (r_field == 2'd0) ? 2'd2 : r_field - 2'd1;
    end
  end

  always_comb begin
    w_rep_nxt = r_rep;
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    w_inc_nxt = 1'b0;
    w_dec_nxt = 1'b0;
    w_held    = r_dir ? dis : au;
    w_limit   = (r_rep == RP_DELAY) ? DELAY_LAST : RATE_LAST;
    if (r_mode == NORMAL || w_mode_chg) begin
      w_rep_nxt = RP_IDLE;
      w_cnt_nxt = '0;
    end else if (w_rise[B_AU] && !dis) begin
      w_inc_nxt = 1'b1;
      w_rep_nxt = RP_DELAY;
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
    end else if (w_rise[B_DIS] && !au) begin
      w_dec_nxt = 1'b1;
      w_rep_nxt = RP_DELAY;
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b1;
    end else if (r_rep != RP_IDLE) begin
      if (!w_held || (au && dis)) begin
        w_rep_nxt = RP_IDLE;
        w_cnt_nxt = '0;
      end else if (r_cnt == w_limit) begin
        w_inc_nxt = !r_dir;
        w_dec_nxt = r_dir;
        w_rep_nxt = RP_RATE;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_fmt_nxt   = r_fmt ^ w_rise[B_F];
    w_crono_nxt = r_crono;
    // Entering CRONO stops the chrono, and icr is ignored while editing it.
    if (w_mode_chg && w_mode_nxt == CRONO)          w_crono_nxt = 1'b0;
    else if (w_rise[B_ICR] && r_mode != CRONO)      w_crono_nxt = ~r_crono;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev  <= '1;
      r_mode  <= NORMAL;
      r_rep   <= RP_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_field <= 2'd0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_fmt   <= 1'b0;
      r_crono <= 1'b0;
      r_edit  <= 1'b0;
    end else begin
      r_prev  <= w_lvl;
      r_mode  <= w_mode_nxt;
      r_rep   <= w_rep_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_field <= w_field_nxt;
      r_inc   <= w_inc_nxt;
      r_dec   <= w_dec_nxt;
      r_fmt   <= w_fmt_nxt;
      r_crono <= w_crono_nxt;
      r_edit  <= (w_mode_nxt != NORMAL);
    end
  end

  assign mode        = r_mode;
  assign edit_active = r_edit;
  assign field       = r_field;
  assign inc_pulse   = r_inc;
  assign dec_pulse   = r_dec;
  assign fmt_12h     = r_fmt;
  assign crono_run   = r_crono;

endmodule

// File: tb/tb_ctrl_edicion.sv
// Scoreboard bench for ctrl_edicion: stimulus queues expected state and strobes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ctrl_edicion;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic au = 0, dis = 0, l = 0, r = 0, f = 0, prh = 0, prf = 0, prc = 0, icr = 0;
  logic [1:0] mode, field;
  logic edit_active, inc_pulse, dec_pulse, fmt_12h, crono_run;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {int cyc; logic [1:0] mode; logic [1:0] field; logic fmt; logic crono;} st_t;
  typedef struct {int cyc; logic dec;} pl_t;
  st_t sq[$];
  pl_t pq[$];

  ctrl_edicion #(.REPEAT_DELAY(8), .REPEAT_RATE(3), .CNT_W(4)) dut (
    .clk(clk), .reset(rst), .au(au), .dis(dis), .l(l), .r(r), .f(f),
    .prh(prh), .prf(prf), .prc(prc), .icr(icr),
    .mode(mode), .edit_active(edit_active), .field(field),
    .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .fmt_12h(fmt_12h), .crono_run(crono_run)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Expectation for the outputs produced by the edge just taken.
  task automatic exp_state(input logic [1:0] m, input logic [1:0] fl, input logic fm, input logic cr);
    st_t s;
    s.cyc = cyc; s.mode = m; s.field = fl; s.fmt = fm; s.crono = cr;
    sq.push_back(s);
  endtask

  task automatic exp_pulse(input int c, input logic d);
    pl_t p;
    p.cyc = c; p.dec = d;
    pq.push_back(p);
  endtask

  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      chk("mode",  {6'd0, mode},  {6'd0, sq[0].mode});
      chk("edit",  {7'd0, edit_active}, {7'd0, (sq[0].mode != 2'b00)});
      chk("field", {6'd0, field}, {6'd0, sq[0].field});
      chk("fmt",   {7'd0, fmt_12h},  {7'd0, sq[0].fmt});
      chk("crono", {7'd0, crono_run}, {7'd0, sq[0].crono});
      void'(sq.pop_front());
    end
    while (pq.size() > 0 && pq[0].cyc < cyc) begin
      total++; bad++;
      $display("FAIL pulse_missing: got none want strobe at cyc %0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    if (inc_pulse || dec_pulse) begin
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        chk("pulse_dir", {6'd0, inc_pulse, dec_pulse}, pq[0].dec ? 8'h01 : 8'h02);
        void'(pq.pop_front());
      end else begin
        total++; bad++;
        $display("FAIL pulse_extra @cyc %0d: got inc=%0b dec=%0b want none", cyc, inc_pulse, dec_pulse);
      end
    end else if (pq.size() > 0 && pq[0].cyc == cyc) begin
      total++; bad++;
      $display("FAIL pulse_missing @cyc %0d: got none want strobe", cyc);
      void'(pq.pop_front());
    end
  end

  int k;

  initial begin
    #3;
    chk("rst_out", {mode, field, edit_active, inc_pulse, dec_pulse, fmt_12h},
        8'h00);
    chk("rst_crono", {7'd0, crono_run}, 8'h00);
    step(2);
    rst = 1'b1;
    step(2);
    exp_state(2'd0, 2'd0, 0, 0);

    // prh enters and leaves HORA
    prh = 1; step(1); exp_state(2'd1, 2'd0, 0, 0);
    prh = 0; step(1);
    prh = 1; step(1); exp_state(2'd0, 2'd0, 0, 0);
    prh = 0; step(1);

    // cursor in HORA
    prh = 1; step(1); prh = 0; step(1); exp_state(2'd1, 2'd0, 0, 0);
    r = 1; step(1); exp_state(2'd1, 2'd1, 0, 0); r = 0; step(1);
    r = 1; step(1); exp_state(2'd1, 2'd2, 0, 0); r = 0; step(1);
    r = 1; step(1); exp_state(2'd1, 2'd0, 0, 0); r = 0; step(1);
    r = 1; step(1); exp_state(2'd1, 2'd1, 0, 0); r = 0; step(1);
    l = 1; step(1); exp_state(2'd1, 2'd0, 0, 0); l = 0; step(1);
    l = 1; r = 1; step(1); exp_state(2'd1, 2'd0, 0, 0); l = 0; r = 0; step(1);
    l = 1; step(1); exp_state(2'd1, 2'd2, 0, 0); l = 0; step(1);
    l = 1; step(1); exp_state(2'd1, 2'd1, 0, 0); l = 0; step(1);
    // cursor move lost to a simultaneous mode change
    prf = 1; r = 1; step(1); exp_state(2'd2, 2'd0, 0, 0); prf = 0; r = 0; step(1);

    // auto-repeat in FECHA: strobes at k, k+8, k+11, k+14, k+17
    au = 1; step(1); k = cyc;
    exp_pulse(k, 0); exp_pulse(k + 8, 0); exp_pulse(k + 11, 0);
    exp_pulse(k + 14, 0); exp_pulse(k + 17, 0);
    step(19);
    au = 0; step(8);
    exp_state(2'd2, 2'd0, 0, 0);

    // dec strobe, repeat aborted by dis+au together
    dis = 1; step(1); exp_pulse(cyc, 1);
    step(3); au = 1; step(10); au = 0; dis = 0; step(2);

    // NORMAL: no strobes
    prf = 1; step(1); exp_state(2'd0, 2'd0, 0, 0); prf = 0; step(1);
    au = 1; step(1); au = 0; step(1); dis = 1; step(1); dis = 0; step(1);
    // au held while entering FECHA: no strobe until re-pressed
    au = 1; step(1); prf = 1; step(1); exp_state(2'd2, 2'd0, 0, 0); prf = 0;
    step(12); au = 0; step(1);
    au = 1; step(1); exp_pulse(cyc, 0); au = 0; step(2);
    prf = 1; step(1); exp_state(2'd0, 2'd0, 0, 0); prf = 0; step(1);

    // flags
    icr = 1; step(1); exp_state(2'd0, 2'd0, 0, 1); icr = 0; step(1);
    prc = 1; step(1); exp_state(2'd3, 2'd0, 0, 0); prc = 0; step(1);
    icr = 1; step(1); exp_state(2'd3, 2'd0, 0, 0); icr = 0; step(1);
    f = 1; step(1); exp_state(2'd3, 2'd0, 1, 0); f = 0; step(1);
    f = 1; step(1); exp_state(2'd3, 2'd0, 0, 0); f = 0; step(1);
    prc = 1; step(1); exp_state(2'd0, 2'd0, 0, 0); prc = 0; step(1);
    // priority prh > prf > prc
    prh = 1; prf = 1; prc = 1; step(1); exp_state(2'd1, 2'd0, 0, 0);
    prh = 0; prf = 0; prc = 0; step(1);
    f = 1; icr = 1; step(1); exp_state(2'd1, 2'd0, 1, 1); f = 0; icr = 0; step(1);

    // async reset in the middle of DELAY
    au = 1; step(1); exp_pulse(cyc, 0);
    step(3);
    rst = 1'b0; #1;
    chk("arst_out", {mode, field, edit_active, inc_pulse, dec_pulse, fmt_12h},
        8'h00);
    chk("arst_crono", {7'd0, crono_run}, 8'h00);
    step(2);
    rst = 1'b1; step(10); exp_state(2'd0, 2'd0, 0, 0);
    au = 0; step(1); au = 1; step(1); au = 0; step(1);
    prh = 1; step(1); exp_state(2'd1, 2'd0, 0, 0); prh = 0; step(1);
    au = 1; step(1); exp_pulse(cyc, 0); au = 0; step(4);

    @(negedge clk); #1;
    while (sq.size() > 0) begin
      total++; bad++;
      $display("FAIL state_unchecked: got pending want none (cyc %0d)", sq[0].cyc);
      void'(sq.pop_front());
    end
    while (pq.size() > 0) begin
      total++; bad++;
      $display("FAIL pulse_missing: got none want strobe at cyc %0d", pq[0].cyc);
      void'(pq.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
